ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader.sv | 159 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: bit-serial loader for an eFPGA configuration flip-flop
// chain. Host words arrive on a valid/ready stream and are shifted LSB-first
// into ccff_head, one bit per prog_clk cycle while ccff_shift_en is high,
// for exactly CHAIN_LEN bits per load.
//
// Optional build macro CCFF_READBACK_EN: samples ccff_tail during every shift
// cycle and returns the bits that fall out of the chain as rb_data words
// (strobed by rb_valid). When the macro is undefined, rb_data/rb_valid are 0.
//
// Host handshake: a word transfers on a rising prog_clk edge where
// cfg_valid && cfg_ready. The host keeps cfg_valid and cfg_data stable until
// that edge. cfg_ready is high only in FETCH and never depends on cfg_valid.
module ccff_chain_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_left,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
);

   localparam int WC_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] shreg;
   logic [WC_W-1:0]   word_cnt;
   logic [CNT_W-1:0]  bits_left_q;
   logic              accept;
   logic              word_last;

   // State register
   always_ff @(posedge prog_clk) begin
      if (pReset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nxt     = state;
      cfg_ready     = 1'b0;
      ccff_shift_en = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      accept        = 1'b0;
      word_last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            cfg_ready = 1'b1;
            busy      = 1'b1;
            if (cfg_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            ccff_shift_en = 1'b1;
            busy          = 1'b1;
            if (word_cnt == WC_W'(1)) begin
               word_last = 1'b1;
               // bits_left is still pre-decrement here, so 1 means this is the final bit
               state_nxt = (bits_left_q == CNT_W'(1)) ? DONE : FETCH;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift register, per-word bit counter and per-load bit counter
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         shreg       <= '0;
         word_cnt    <= '0;
         bits_left_q <= '0;
      end else begin
         if (state == IDLE && start) bits_left_q <= CNT_W'(CHAIN_LEN);
         if (accept) begin
            shreg <= cfg_data;
            // A short final word only shifts the bits the chain still needs
            word_cnt <= (int'(bits_left_q) < WORD_W) ? WC_W'(bits_left_q) : WC_W'(WORD_W);
         end
         if (ccff_shift_en) begin
            shreg       <= shreg >> 1;
            word_cnt    <= word_cnt - WC_W'(1);
            bits_left_q <= bits_left_q - CNT_W'(1);
         end
      end
   end

   assign ccff_head = ccff_shift_en & shreg[0];
   assign bits_left = bits_left_q;

`ifdef CCFF_READBACK_EN
   logic [WORD_W-1:0] rb_acc;
   logic [WORD_W-1:0] rb_word;
   logic [WC_W-1:0]   rb_idx;

   // Current readback word including this cycle's tail sample
   always_comb begin
      rb_word = rb_acc | (WORD_W'(ccff_tail) << rb_idx);
   end

   // Readback accumulator; words align with the outgoing word boundaries
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         rb_acc   <= '0;
         rb_idx   <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (ccff_shift_en) begin
            if (word_last) begin
               rb_data  <= rb_word;
               rb_valid <= 1'b1;
               rb_acc   <= '0;
               rb_idx   <= '0;
            end else begin
               rb_acc <= rb_word;
               rb_idx <= rb_idx + WC_W'(1);
            end
         end
      end
   end
`else
   logic unused_tail;

   assign rb_data     = '0;
   assign rb_valid    = 1'b0;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 70-bit chain with 32-bit words, plus a
// CHAIN_LEN=1 instance. A fabric chain model sits on ccff_head/ccff_tail.
module tb_ccff_chain_loader;

   localparam int WORD_W    = 32;
   localparam int CHAIN_LEN = 70;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int CNT_W1    = $clog2(1 + 1);

   // ---------------- clock / reset ----------------
   logic prog_clk = 1'b0;
   logic pReset   = 1'b1;
   always #5 prog_clk = ~prog_clk;

   // ---------------- DUT (CHAIN_LEN=70) ----------------
   logic              start = 1'b0;
   logic [WORD_W-1:0] cfg_data = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  bits_left;
   logic [WORD_W-1:0] rb_data;
   logic              rb_valid;

   ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
      .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
      .bits_left(bits_left), .rb_data(rb_data), .rb_valid(rb_valid)
   );

   // fabric chain model: shifts in at [0], tail is the oldest bit
   logic [CHAIN_LEN-1:0] chain = '0;
   always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   assign ccff_tail = chain[CHAIN_LEN-1];

   // ---------------- DUT (CHAIN_LEN=1) ----------------
   logic              start1 = 1'b0;
   logic [WORD_W-1:0] data1 = '0;
   logic              valid1 = 1'b0;
   logic              ready1, head1, sen1, tail1, busy1, done1, rbv1;
   logic [CNT_W1-1:0] bl1;
   logic [WORD_W-1:0] rb1;
   logic              chain1 = 1'b0;

   ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(1)) dut1 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start1), .cfg_data(data1),
      .cfg_valid(valid1), .cfg_ready(ready1), .ccff_head(head1),
      .ccff_shift_en(sen1), .ccff_tail(tail1), .busy(busy1), .done(done1),
      .bits_left(bl1), .rb_data(rb1), .rb_valid(rbv1)
   );
   always @(posedge prog_clk) if (sen1) chain1 <= head1;
   assign tail1 = chain1;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   bit                exp_q[$];      // expected ccff_head bits of the current load
   logic [WORD_W-1:0] rb_exp_q[$];   // expected readback words
   int  burst_q[$];                  // lengths of shift_en-high runs
   int  shift_in_load = 0;
   int  shift_total   = 0;
   int  run_len       = 0;
   int  done_cnt      = 0;
   int  rb_cnt        = 0;
   bit  rb_check      = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   // compare process: DUT outputs against the model on every cycle
   always @(negedge prog_clk) begin
      if (!pReset) begin
         check("ready_implies_busy", 128'(cfg_ready & ~busy), 128'(0));
         if (ccff_shift_en) begin
            if (exp_q.size() == 0) fail_now("unexpected_shift");
            else check("ccff_head", 128'(ccff_head), 128'(exp_q.pop_front()));
            check("bits_left_shift", 128'(bits_left), 128'(CHAIN_LEN - shift_in_load));
            shift_in_load++;
            shift_total++;
            run_len++;
         end else begin
            if (run_len > 0) begin
               burst_q.push_back(run_len);
               run_len = 0;
            end
            if (busy) check("bits_left_wait", 128'(bits_left), 128'(CHAIN_LEN - shift_in_load));
         end
         if (done) begin
            done_cnt++;
            check("done_busy_low", 128'(busy), 128'(0));
            check("done_bits_left", 128'(bits_left), 128'(0));
            check("done_shift_count", 128'(shift_in_load), 128'(CHAIN_LEN));
            shift_in_load = 0;
         end
`ifdef CCFF_READBACK_EN
         if (rb_valid) begin
            rb_cnt++;
            if (rb_check) begin
               if (rb_exp_q.size() == 0) fail_now("rb_extra_word");
               else check("rb_data", 128'(rb_data), 128'(rb_exp_q.pop_front()));
            end
         end
`else
         check("rb_tied_off", 128'({rb_valid, rb_data}), 128'(0));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input bit incl_rb);
      check({tag, "_cfg_ready"}, 128'(cfg_ready), 128'(0));
      check({tag, "_ccff_head"}, 128'(ccff_head), 128'(0));
      check({tag, "_shift_en"}, 128'(ccff_shift_en), 128'(0));
      check({tag, "_busy"}, 128'(busy), 128'(0));
      check({tag, "_done"}, 128'(done), 128'(0));
      check({tag, "_bits_left"}, 128'(bits_left), 128'(0));
      if (incl_rb) begin
         check({tag, "_rb_data"}, 128'(rb_data), 128'(0));
         check({tag, "_rb_valid"}, 128'(rb_valid), 128'(0));
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge prog_clk);
         if (cfg_ready) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // one load of three words; optional host stall, stray start, or reset mid-word-2
   task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                           input logic [WORD_W-1:0] w2, input int stall_before,
                           input bit extra_start, input int reset_at);
      logic [WORD_W-1:0] words [3];
      logic [WORD_W-1:0] w;
      int  d0;
      bit  ok;
      bit  seen;
      words = '{w0, w1, w2};
      for (int i = 0; i < CHAIN_LEN; i++) begin
         w = words[i / WORD_W];
         exp_q.push_back(bit'(w >> (i % WORD_W)));
      end
      burst_q.delete();
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == stall_before) begin
            wait_ready(ok);
            if (!ok) begin fail_now("stall_ready_timeout"); return; end
            for (int s = 0; s < 5; s++) begin
               if (s > 0) @(negedge prog_clk);
               check("stall_shift_en", 128'(ccff_shift_en), 128'(0));
               check("stall_cfg_ready", 128'(cfg_ready), 128'(1));
            end
            cfg_data  = words[k];
            cfg_valid = 1'b1;
            tick();
         end else begin
            cfg_data  = words[k];
            cfg_valid = 1'b1;
            wait_ready(ok);
            if (!ok) begin fail_now("cfg_ready_timeout"); cfg_valid = 1'b0; return; end
            tick();
         end
         cfg_valid = 1'b0;
         cfg_data  = $urandom;
         if (k == 0 && extra_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         if (k == 1 && reset_at > 0) begin
            for (int n = 0; n < 200 && shift_in_load < reset_at; n++) tick();
            pReset = 1'b1;
            tick();
            pReset = 1'b0;
            exp_q.delete();
            shift_in_load = 0;
            run_len = 0;
            return;
         end
      end
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         tick();
         seen = (done_cnt != d0);
      end
      if (!seen) fail_now("done_timeout");
      repeat (5) tick();
      check("one_done_pulse", 128'(done_cnt - d0), 128'(1));
      check("exp_queue_drained", 128'(exp_q.size()), 128'(0));
      @(negedge prog_clk);
      check_idle("after_load", 1'b0);
   endtask

   // ---------------- test sequence ----------------
   localparam logic [WORD_W-1:0] P1_0 = 32'hA5A5_A5A5;
   localparam logic [WORD_W-1:0] P1_1 = 32'h0F0F_0F0F;
   localparam logic [WORD_W-1:0] P1_2 = 32'h0000_003C;
   localparam logic [WORD_W-1:0] P2_0 = 32'h1234_5678;
   localparam logic [WORD_W-1:0] P2_1 = 32'hDEAD_BEEF;
   localparam logic [WORD_W-1:0] P2_2 = 32'hFFFF_FF15;

   logic [CHAIN_LEN-1:0] chain_t1;
   int rb0;
   int t0;

   task automatic check_bursts(input string tag);
      check({tag, "_burst_count"}, 128'(burst_q.size()), 128'(3));
      if (burst_q.size() == 3) begin
         check({tag, "_burst0"}, 128'(burst_q[0]), 128'(32));
         check({tag, "_burst1"}, 128'(burst_q[1]), 128'(32));
         check({tag, "_burst2"}, 128'(burst_q[2]), 128'(6));
      end
   endtask

   task automatic test_chain_len_one();
      int  sen_n, sen_c, done_c, acc_n;
      logic head_seen;
      sen_n = 0; sen_c = -1; done_c = -1; acc_n = 0; head_seen = 1'b0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      data1  = 32'h8000_0005;
      valid1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge prog_clk);
         if (ready1 && valid1) acc_n++;
         if (sen1) begin
            sen_n++;
            sen_c = c;
            head_seen = head1;
            check("len1_bits_left_shift", 128'(bl1), 128'(1));
         end
         if (done1) begin
            done_c = c;
            check("len1_done_busy", 128'(busy1), 128'(0));
         end
         tick();
         if (acc_n > 0) valid1 = 1'b0;
      end
      check("len1_words_accepted", 128'(acc_n), 128'(1));
      check("len1_shift_cycles", 128'(sen_n), 128'(1));
      check("len1_head_bit", 128'(head_seen), 128'(1));
      check("len1_done_after_shift", 128'(done_c), 128'(sen_c + 1));
      check("len1_bits_left_end", 128'(bl1), 128'(0));
      check("len1_busy_end", 128'(busy1), 128'(0));
   endtask

   initial begin
      // reset values while pReset is held
      repeat (2) tick();
      @(negedge prog_clk);
      check_idle("reset", 1'b1);
      check("reset_len1_outputs", 128'({ready1, head1, sen1, busy1, done1, bl1, rbv1, rb1}), 128'(0));
      tick();
      pReset = 1'b0;
      repeat (2) tick();

      // 1: plain load with valid held high
      run_load(P1_0, P1_1, P1_2, -1, 1'b0, 0);
      check_bursts("t1");
      chain_t1 = chain;
      check("t1_chain69", 128'(chain[69]), 128'(1));
      check("t1_chain68", 128'(chain[68]), 128'(0));
      check("t1_chain37", 128'(chain[37]), 128'(1));
      check("t1_chain33", 128'(chain[33]), 128'(0));
      check("t1_chain0", 128'(chain[0]), 128'(1));
      check("t1_chain4", 128'(chain[4]), 128'(0));

      // 2: host underrun before word 2
      chain = '0;
      run_load(P1_0, P1_1, P1_2, 1, 1'b0, 0);
      check_bursts("t2");
      check("t2_chain_equal_t1", 128'(chain), 128'(chain_t1));

      // 3: load P1, then P2 returns P1 on readback
      run_load(P1_0, P1_1, P1_2, -1, 1'b0, 0);
      rb_exp_q = '{P1_0, P1_1, P1_2 & 32'h0000_003F};
      rb0 = rb_cnt;
      rb_check = 1'b1;
      run_load(P2_0, P2_1, P2_2, -1, 1'b0, 0);
      rb_check = 1'b0;
`ifdef CCFF_READBACK_EN
      check("t3_rb_pulses", 128'(rb_cnt - rb0), 128'(3));
      check("t3_rb_queue_drained", 128'(rb_exp_q.size()), 128'(0));
`endif
      rb_exp_q.delete();

      // 4: reset during word 2, then a full load
      run_load(P1_0, P1_1, P1_2, -1, 1'b0, 45);
      @(negedge prog_clk);
      check_idle("t4_after_reset", 1'b1);
      run_load(P2_0, P2_1, P2_2, -1, 1'b0, 0);
      check_bursts("t4");

      // 5: start pulsed while busy is ignored
      t0 = shift_total;
      run_load(P2_0, P2_1, P2_2, -1, 1'b1, 0);
      check("t5_shift_total", 128'(shift_total - t0), 128'(CHAIN_LEN));
      check_bursts("t5");

      // 6: CHAIN_LEN=1 instance
      test_chain_len_one();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
